// File: rtl/dp_ctrl_arbiter.sv
// Two-master arbiter for the DataPath control bundle (ControlUnit vs host loader).
// Registered round-robin grant, bounded bursts, one dead cycle between owners.
module dp_ctrl_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CW        = 26
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req0,
    input  logic          last0,
    input  logic [CW-1:0] ctl0,
    output logic          gnt0,
    input  logic          req1,
    input  logic          last1,
    input  logic [CW-1:0] ctl1,
    output logic          gnt1,
    output logic [CW-1:0] dp_ctl,
    output logic          preempt,
    output logic [1:0]    arb_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        SWITCH = 2'd3
    } state_t;

    localparam int D_WR_BIT   = 25;
    localparam int RF_WEN_BIT = 23;
    localparam logic [4:0] BURST_LAST = (MAX_BURST == 0) ? 5'd0 : 5'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic [4:0] burst_cnt_q, burst_cnt_d;
    logic       preempt_q, preempt_d;

    logic own_req, own_last, other_req, limit_hit, release_now;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            burst_cnt_q <= 5'd0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            burst_cnt_q <= burst_cnt_d;
            preempt_q   <= preempt_d;
        end
    end

    always_comb begin
        own_req     = (state_q == GRANT1) ? req1  : req0;
        own_last    = (state_q == GRANT1) ? last1 : last0;
        other_req   = (state_q == GRANT1) ? req0  : req1;
        limit_hit   = (MAX_BURST != 0) && (burst_cnt_q == BURST_LAST) && other_req;
        release_now = (own_req && own_last) || !own_req || limit_hit;

        state_d     = state_q;
        prio_d      = prio_q;
        burst_cnt_d = 5'd0;
        preempt_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 && req1)
                    state_d = prio_q ? GRANT1 : GRANT0;
                else if (req0)
                    state_d = GRANT0;
                else if (req1)
                    state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (release_now) begin
                    state_d   = other_req ? SWITCH : IDLE;
                    prio_d    = (state_q == GRANT0);
                    // A coinciding last makes this a normal release, not a preemption.
                    preempt_d = limit_hit && own_req && !own_last;
                end else begin
                    burst_cnt_d = (burst_cnt_q == 5'd31) ? 5'd31 : burst_cnt_q + 5'd1;
                end
            end
            SWITCH: begin
                // prio already names the waiting requester after the release.
                state_d = prio_q ? GRANT1 : GRANT0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dp_ctl = '0;
        case (state_q)
            GRANT0: begin
                dp_ctl = ctl0;
                if (!req0) begin
                    dp_ctl[D_WR_BIT]   = 1'b0;
                    dp_ctl[RF_WEN_BIT] = 1'b0;
                end
            end
            GRANT1: begin
                dp_ctl = ctl1;
                if (!req1) begin
                    dp_ctl[D_WR_BIT]   = 1'b0;
                    dp_ctl[RF_WEN_BIT] = 1'b0;
                end
            end
            default: dp_ctl = '0;
        endcase
    end

    assign gnt0      = (state_q == GRANT0);
    assign gnt1      = (state_q == GRANT1);
    assign preempt   = preempt_q;
    assign arb_state = state_q;

endmodule

// File: tb/tb_dp_ctrl_arbiter.sv
// Directed, table-driven bench for dp_ctrl_arbiter (MAX_BURST=4); each row is one
// clock cycle of inputs plus the outputs expected during that same cycle.
module tb_dp_ctrl_arbiter;

    localparam logic [25:0] C0  = 26'h1234567;
    localparam logic [25:0] C1  = 26'h2ABCDEF;
    localparam logic [25:0] FF  = 26'h3FFFFFF;
    localparam logic [25:0] WG  = 26'h28ABCDE;
    localparam logic [25:0] WGO = 26'h00ABCDE;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req0, last0, req1, last1;
    logic [25:0] ctl0, ctl1;
    logic        gnt0, gnt1, preempt;
    logic [25:0] dp_ctl;
    logic [1:0]  arb_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        r0;
        logic        l0;
        logic [25:0] c0;
        logic        r1;
        logic        l1;
        logic [25:0] c1;
        logic        g0;
        logic        g1;
        logic [25:0] dp;
        logic        pre;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[$];

    dp_ctrl_arbiter #(.MAX_BURST(4), .CW(26)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .last0(last0), .ctl0(ctl0), .gnt0(gnt0),
        .req1(req1), .last1(last1), .ctl1(ctl1), .gnt1(gnt1),
        .dp_ctl(dp_ctl), .preempt(preempt), .arb_state(arb_state)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic rst, input logic r0, input logic l0,
                                input logic [25:0] c0, input logic r1, input logic l1,
                                input logic [25:0] c1, input logic g0, input logic g1,
                                input logic [25:0] dp, input logic pre, input logic [1:0] st);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.l0 = l0; v.c0 = c0; v.r1 = r1; v.l1 = l1; v.c1 = c1;
        v.g0 = g0; v.g1 = g1; v.dp = dp; v.pre = pre; v.st = st;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [30:0] act, exp_v;
        @(negedge Clk);
        Reset = v.rst; req0 = v.r0; last0 = v.l0; ctl0 = v.c0;
        req1 = v.r1; last1 = v.l1; ctl1 = v.c1;
        #1;
        act   = {gnt0, gnt1, dp_ctl, preempt, arb_state};
        exp_v = {v.g0, v.g1, v.dp, v.pre, v.st};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got gnt0=%b gnt1=%b dp=%h pre=%b st=%0d, want gnt0=%b gnt1=%b dp=%h pre=%b st=%0d",
                     name, gnt0, gnt1, dp_ctl, preempt, arb_state, v.g0, v.g1, v.dp, v.pre, v.st);
        end else begin
            $display("ok   %s: gnt0=%b gnt1=%b dp=%h pre=%b st=%0d",
                     name, gnt0, gnt1, dp_ctl, preempt, arb_state);
        end
    endtask

    initial begin
        Reset = 1'b1; req0 = 0; last0 = 0; req1 = 0; last1 = 0; ctl0 = FF; ctl1 = C1;
        repeat (2) @(negedge Clk);

        // Reset state and hold, including a request masked by reset.
        tbl.push_back(mk(0, 0,0,FF, 0,0,C1,  0,0,26'h0,0,2'd0));
        tbl.push_back(mk(0, 0,0,FF, 0,0,C1,  0,0,26'h0,0,2'd0));
        tbl.push_back(mk(0, 0,0,FF, 0,0,C1,  0,0,26'h0,0,2'd0));
        tbl.push_back(mk(1, 1,0,FF, 0,0,C1,  0,0,26'h0,0,2'd0));
        tbl.push_back(mk(0, 0,0,FF, 0,0,C1,  0,0,26'h0,0,2'd0));
        // Single request, three granted cycles, last on the third.
        tbl.push_back(mk(0, 1,0,FF, 0,0,C1,  0,0,26'h0,0,2'd0));
        tbl.push_back(mk(0, 1,0,FF, 0,0,C1,  1,0,FF,   0,2'd1));
        tbl.push_back(mk(0, 1,0,FF, 0,0,C1,  1,0,FF,   0,2'd1));
        tbl.push_back(mk(0, 1,1,FF, 0,0,C1,  1,0,FF,   0,2'd1));
        tbl.push_back(mk(0, 0,0,FF, 0,0,C1,  0,0,26'h0,0,2'd0));
        // Tie from reset: 0 first, SWITCH, 1, SWITCH, 0 again.
        tbl.push_back(mk(1, 0,0,C0, 0,0,C1,  0,0,26'h0,0,2'd0));
        tbl.push_back(mk(0, 1,0,C0, 1,0,C1,  0,0,26'h0,0,2'd0));
        tbl.push_back(mk(0, 1,0,C0, 1,0,C1,  1,0,C0,   0,2'd1));
        tbl.push_back(mk(0, 1,1,C0, 1,0,C1,  1,0,C0,   0,2'd1));
        tbl.push_back(mk(0, 1,0,C0, 1,0,C1,  0,0,26'h0,0,2'd3));
        tbl.push_back(mk(0, 1,0,C0, 1,0,C1,  0,1,C1,   0,2'd2));
        tbl.push_back(mk(0, 1,0,C0, 1,1,C1,  0,1,C1,   0,2'd2));
        tbl.push_back(mk(0, 1,0,C0, 1,0,C1,  0,0,26'h0,0,2'd3));
        tbl.push_back(mk(0, 1,1,C0, 0,0,C1,  1,0,C0,   0,2'd1));
        tbl.push_back(mk(0, 0,0,C0, 0,0,C1,  0,0,26'h0,0,2'd0));
        // Write gating when req0 drops mid-grant.
        tbl.push_back(mk(0, 1,0,WG, 0,0,C1,  0,0,26'h0,0,2'd0));
        tbl.push_back(mk(0, 1,0,WG, 0,0,C1,  1,0,WG,   0,2'd1));
        tbl.push_back(mk(0, 0,0,WG, 0,0,C1,  1,0,WGO,  0,2'd1));
        tbl.push_back(mk(0, 0,0,WG, 0,0,C1,  0,0,26'h0,0,2'd0));
        // Release to IDLE with req0 still high re-grants after one IDLE cycle.
        tbl.push_back(mk(0, 1,0,C0, 0,0,C1,  0,0,26'h0,0,2'd0));
        tbl.push_back(mk(0, 1,1,C0, 0,0,C1,  1,0,C0,   0,2'd1));
        tbl.push_back(mk(0, 1,0,C0, 0,0,C1,  0,0,26'h0,0,2'd0));
        tbl.push_back(mk(0, 1,1,C0, 0,0,C1,  1,0,C0,   0,2'd1));
        tbl.push_back(mk(0, 0,0,C0, 0,0,C1,  0,0,26'h0,0,2'd0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Burst limit: host held without last, ControlUnit waiting.
        apply(mk(1, 0,0,C0, 0,0,C1,  0,0,26'h0,0,2'd0), "burst_rst");
        apply(mk(0, 0,0,C0, 1,0,C1,  0,0,26'h0,0,2'd0), "burst_req1");
        for (int k = 0; k < 4; k++)
            apply(mk(0, 1,0,C0, 1,0,C1,  0,1,C1,0,2'd2), $sformatf("burst_g1_%0d", k));
        apply(mk(0, 1,0,C0, 1,0,C1,  0,0,26'h0,1,2'd3), "burst_preempt");
        apply(mk(0, 1,1,C0, 1,0,C1,  1,0,C0,   0,2'd1), "burst_g0");
        apply(mk(0, 0,0,C0, 1,0,C1,  0,0,26'h0,0,2'd3), "burst_switch");
        // Nobody else waiting: the host keeps its grant past the limit.
        for (int k = 0; k < 10; k++)
            apply(mk(0, 0,0,C0, 1,0,C1,  0,1,C1,0,2'd2), $sformatf("hold_g1_%0d", k));
        apply(mk(0, 0,0,C0, 1,1,C1,  0,1,C1,   0,2'd2), "hold_last");
        apply(mk(0, 0,0,C0, 0,0,C1,  0,0,26'h0,0,2'd0), "hold_idle");

        // Reset during GRANT1 at burst_cnt=2: no preempt, prio back to 0.
        apply(mk(0, 0,0,C0, 1,0,C1,  0,0,26'h0,0,2'd0), "rstmid_req1");
        apply(mk(0, 0,0,C0, 1,0,C1,  0,1,C1,   0,2'd2), "rstmid_c0");
        apply(mk(0, 0,0,C0, 1,0,C1,  0,1,C1,   0,2'd2), "rstmid_c1");
        apply(mk(1, 1,0,C0, 1,0,C1,  0,1,C1,   0,2'd2), "rstmid_assert");
        apply(mk(0, 1,0,C0, 1,0,C1,  0,0,26'h0,0,2'd0), "rstmid_idle");
        apply(mk(0, 1,1,C0, 1,0,C1,  1,0,C0,   0,2'd1), "rstmid_prio0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_ctrl_arbiter.md
Name: dp_ctrl_arbiter

Overview:
- Shares the DataPath control bundle between two masters: requester 0 is the ControlUnit and requester 1 is the host/debug loader, which preloads data memory and inspects the register file.
- Sits between the ControlUnit and DataPath inside Processor.
- Grants ownership through a registered req/gnt handshake, with round-robin priority, a bounded burst length and a one-cycle turnaround between owners.
- Drives a safe idle bundle (no writes) whenever nobody owns the datapath.

Parameters:
- MAX_BURST, 16, maximum consecutive granted cycles before forced release if the other requester is waiting; 0 = unlimited.
- CW, 26, control bundle width; fixed layout, not to be changed independently.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  reset.
- req0  input  1  ControlUnit requests datapath.
- last0  input  1  ControlUnit's final cycle of the transaction.
- ctl0  input  CW  ControlUnit bundle.
- gnt0  output  1  ControlUnit owns datapath this cycle.
- req1  input  1  host request.
- last1  input  1  host final cycle.
- ctl1  input  CW  host bundle.
- gnt1  output  1  host owns datapath.
- dp_ctl  output  CW  bundle to DataPath.
- preempt  output  1  one-cycle pulse when a grant is force-released.
- arb_state  output  2  current FSM state (debug).

Bundle layout (ctl0, ctl1, dp_ctl):
- [25] D_Wr, [24] RF_s, [23] RF_W_en, [22:15] D_Addr, [14:11] RF_W_Addr, [10:7] RF_Ra_Addr, [6:3] RF_Rb_Addr, [2:0] ALU_s0.

Behaviour:
- Clocking and reset: one clock, Clk. Reset is synchronous and active-high.
- State on Reset: state=IDLE, prio=0 (ControlUnit wins first tie), burst_cnt=0, preempt=0.
- Outputs on Reset: gnt0=gnt1=0, dp_ctl=0.
- Reset mid-grant: the grant is dropped at that edge with no turnaround. The in-flight transaction is abandoned and its requester must re-request.
- States and encoding: IDLE=0, GRANT0=1, GRANT1=2, SWITCH=3.
- Output decode: gnt0=(state==GRANT0) and gnt1=(state==GRANT1). Both are registered-state decodes and are never high together.
- dp_ctl source: ctl0 in GRANT0 and ctl1 in GRANT1. In IDLE and SWITCH it is all zeros, so D_Wr=RF_W_en=0 and ALU_s0=0.
- Write-enable gating: in GRANTx, if reqx=0 then D_Wr and RF_W_en are forced to 0. Other fields pass through.
- Grant latency: a request seen at edge n with state IDLE makes gnt high in the cycle after edge n (1-cycle latency).
- IDLE transitions:
  - only req0 -> GRANT0; only req1 -> GRANT1.
  - both -> GRANT(prio).
  - none -> stay IDLE.
- GRANTx release conditions: (reqx & lastx), or !reqx, or (MAX_BURST!=0 & burst_cnt==MAX_BURST-1 & req_other).
- The bundle in the release cycle is applied in full. This covers the last cycle and the forced-release cycle.
- After release: if req_other, go to SWITCH, else go to IDLE.
- prio is set to the other requester on every release.
- SWITCH: unconditional -> GRANT(other) after one dead cycle, even if req_other dropped (the grant then releases immediately via !req).
- burst_cnt: cleared on entry to GRANTx, +1 per GRANTx cycle, saturates at 2^5-1.
- preempt is high for exactly the cycle after a forced release. A forced release is one where the limit triggered while lastx=0 and reqx=1.
- Forced-release priority: if lastx coincides with the limit, it is a normal release and preempt=0.
- Simultaneous requests in IDLE resolve by prio. A requester whose grant just ended cannot win the next tie.
- A release to IDLE with reqx still high re-grants x after one IDLE cycle (2 cycles later) if the other requester is silent.

Test Plan:
- Reset with both reqs low -> gnt0=gnt1=0, dp_ctl=0, arb_state=0; hold 3 cycles, no change.
- Single request: req0=1, ctl0=26'h3FFFFFF, last0 asserted on the 3rd granted cycle.
  - gnt0 high 1 cycle after req, for exactly 3 cycles; dp_ctl=26'h3FFFFFF while granted.
  - Then IDLE with dp_ctl=0.
- Tie with reversal: req0=req1=1 from reset.
  - GRANT0 first; after last0, exactly one SWITCH cycle with dp_ctl=0, then gnt1.
  - Next tie goes to requester 0 again only after requester 1 releases.
- Burst limit: MAX_BURST=4, req1 held with last1=0, req0 asserted.
  - gnt1 high 4 cycles; preempt pulses once; SWITCH; gnt0.
  - With req0 low, gnt1 stays high indefinitely.
- Write gating: in GRANT0, drop req0 with ctl0 D_Wr=1, RF_W_en=1 -> dp_ctl[25]=0 and dp_ctl[23]=0 that cycle, then next state IDLE.
- Reset mid-operation: assert Reset during GRANT1 at burst_cnt=2 -> next cycle IDLE, gnt1=0, dp_ctl=0, prio=0, no preempt pulse.
